// File: rtl/bf_weight_loader.sv
// Beamforming weight loader: writes land in a shadow bank; a commit copies the shadow bank
// into the active bank on the next frame sync. Optional feature macro: BF_WLOAD_CHECKSUM_EN.
module bf_weight_loader #(
    parameter int W_BITS = 5,
    parameter int N_CH   = 8,
    parameter int AW     = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [W_BITS-1:0]              wr_data_i,
    input  logic                           commit_i,
    input  logic                           frame_sync_i,
`ifdef BF_WLOAD_CHECKSUM_EN
    input  logic [W_BITS-1:0]              commit_sum_i,
`endif
    output logic [N_CH-1:0][W_BITS-1:0]   w_cos_1_o,
    output logic [N_CH-1:0][W_BITS-1:0]   w_sin_1_o,
    output logic [N_CH-1:0][W_BITS-1:0]   w_cos_2_o,
    output logic [N_CH-1:0][W_BITS-1:0]   w_sin_2_o,
    output logic                           pending_o,
    output logic                           applied_o,
    output logic                           err_o
);

    localparam int N_WORDS  = 4 * N_CH;
    localparam int IDX_BITS = $clog2(N_WORDS);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                wr_ready_q, wr_ready_d;
    logic                pending_q, pending_d;
    logic                applied_q, applied_d;
    logic                err_q, err_d;
    logic [W_BITS-1:0]   shadow_q [N_WORDS];
    logic [W_BITS-1:0]   shadow_d [N_WORDS];
    logic [W_BITS-1:0]   active_q [N_WORDS];
    logic [W_BITS-1:0]   active_d [N_WORDS];

    logic                wr_fire;
    logic                addr_ok;
    logic                commit_ok;
    logic [IDX_BITS-1:0] wr_idx;

    assign wr_fire = wr_valid_i & wr_ready_q;
    assign wr_idx  = wr_addr_i[IDX_BITS-1:0];

    // Only a wider address space can point past the last weight word.
    generate
        if ((1 << AW) > N_WORDS) begin : g_addr_chk
            localparam logic [AW-1:0] ADDR_LIMIT = AW'(N_WORDS);
            assign addr_ok = (wr_addr_i < ADDR_LIMIT);
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

`ifdef BF_WLOAD_CHECKSUM_EN
    logic [W_BITS-1:0] sum_q, sum_d, sum_now;

    // A write in the commit cycle belongs to that commit, so it is folded in before comparing.
    assign sum_now   = wr_fire ? (sum_q ^ wr_data_i) : sum_q;
    assign commit_ok = (sum_now == commit_sum_i);
`else
    assign commit_ok = 1'b1;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        applied_d = 1'b0;
        err_d     = 1'b0;
`ifdef BF_WLOAD_CHECKSUM_EN
        sum_d     = sum_now;
`endif

        if (wr_fire) begin
            if (addr_ok) shadow_d[wr_idx] = wr_data_i;
            else         err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (commit_i) begin
                    if (commit_ok) state_d = PENDING;
                    else           err_d   = 1'b1;
                end
            end
            PENDING: begin
                // Writes are stalled here, so shadow_q is stable for the bulk copy.
                if (frame_sync_i) begin
                    active_d  = shadow_q;
                    applied_d = 1'b1;
                    state_d   = IDLE;
`ifdef BF_WLOAD_CHECKSUM_EN
                    sum_d     = '0;
`endif
                end
            end
        endcase

        wr_ready_d = (state_d == IDLE);
        pending_d  = (state_d == PENDING);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ready_q <= 1'b1;
            pending_q  <= 1'b0;
            applied_q  <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: both banks are reset because bf_top must see known zero weights after reset.
            for (int i = 0; i < N_WORDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
`ifdef BF_WLOAD_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            wr_ready_q <= wr_ready_d;
            pending_q  <= pending_d;
            applied_q  <= applied_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
`ifdef BF_WLOAD_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_cos_1_o[c] = active_q[c];
            w_sin_1_o[c] = active_q[N_CH + c];
            w_cos_2_o[c] = active_q[2*N_CH + c];
            w_sin_2_o[c] = active_q[3*N_CH + c];
        end
    end

    assign wr_ready_o = wr_ready_q;
    assign pending_o  = pending_q;
    assign applied_o  = applied_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_bf_weight_loader.sv
// Directed self-checking bench for bf_weight_loader; define BF_WLOAD_CHECKSUM_EN to also
// exercise the commit checksum.
module tb_bf_weight_loader;

    localparam int W_BITS = 5;
    localparam int N_CH   = 8;
    localparam int AW     = 5;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         wr_valid_i;
    logic                         wr_ready_o;
    logic [AW-1:0]                wr_addr_i;
    logic [W_BITS-1:0]            wr_data_i;
    logic                         commit_i;
    logic                         frame_sync_i;
`ifdef BF_WLOAD_CHECKSUM_EN
    logic [W_BITS-1:0]            commit_sum_i;
`endif
    logic [N_CH-1:0][W_BITS-1:0]  w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o;
    logic                         pending_o, applied_o, err_o;

    int checks   = 0;
    int failures = 0;

    logic [N_CH-1:0][W_BITS-1:0] exp_cos1, exp_sin1, exp_cos2, exp_sin2;
    logic [N_CH-1:0][W_BITS-1:0] zero_bank;

    bf_weight_loader #(.W_BITS(W_BITS), .N_CH(N_CH), .AW(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .commit_i     (commit_i),
        .frame_sync_i (frame_sync_i),
`ifdef BF_WLOAD_CHECKSUM_EN
        .commit_sum_i (commit_sum_i),
`endif
        .w_cos_1_o    (w_cos_1_o),
        .w_sin_1_o    (w_sin_1_o),
        .w_cos_2_o    (w_cos_2_o),
        .w_sin_2_o    (w_sin_2_o),
        .pending_o    (pending_o),
        .applied_o    (applied_o),
        .err_o        (err_o)
    );

    always #5 clock = ~clock;

    // Inputs are driven between edges; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic write(input logic [AW-1:0] addr, input logic [W_BITS-1:0] data);
        wr_valid_i = 1'b1;
        wr_addr_i  = addr;
        wr_data_i  = data;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
    endtask

    task automatic pulse_sync();
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        wr_valid_i   = 1'b0;
        wr_addr_i    = '0;
        wr_data_i    = '0;
        commit_i     = 1'b0;
        frame_sync_i = 1'b0;
`ifdef BF_WLOAD_CHECKSUM_EN
        commit_sum_i = '0;
`endif
        zero_bank    = '0;
        for (int c = 0; c < N_CH; c++) begin
            exp_cos1[c] = W_BITS'(c);
            exp_sin1[c] = W_BITS'(N_CH + c);
            exp_cos2[c] = W_BITS'(2*N_CH + c);
            exp_sin2[c] = W_BITS'(3*N_CH + c);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1. Reset state
        check("rst_wr_ready", 64'(wr_ready_o), 64'd1);
        check("rst_pending",  64'(pending_o),  64'd0);
        check("rst_applied",  64'(applied_o),  64'd0);
        check("rst_err",      64'(err_o),      64'd0);
        check("rst_cos1",     64'(w_cos_1_o),  64'(zero_bank));
        check("rst_sin1",     64'(w_sin_1_o),  64'(zero_bank));
        check("rst_cos2",     64'(w_cos_2_o),  64'(zero_bank));
        check("rst_sin2",     64'(w_sin_2_o),  64'(zero_bank));

        // 2. Fill all 32 words with data = address, commit, sync 10 cycles later
        for (int a = 0; a < 4*N_CH; a++) write(AW'(a), W_BITS'(a));
        check("fill_err",      64'(err_o),     64'd0);
        check("fill_no_apply", 64'(w_sin_2_o), 64'(zero_bank));
        pulse_commit();
        check("commit_pending",  64'(pending_o),  64'd1);
        check("commit_wr_ready", 64'(wr_ready_o), 64'd0);
        for (int i = 0; i < 9; i++) tick();
        check("wait_sin2_held", 64'(w_sin_2_o), 64'(zero_bank));
        check("wait_cos1_held", 64'(w_cos_1_o), 64'(zero_bank));
        check("wait_applied",   64'(applied_o), 64'd0);
        pulse_sync();
        check("apply_sin2_7",  64'(w_sin_2_o[7]), 64'd31);
        check("apply_cos1",    64'(w_cos_1_o),    64'(exp_cos1));
        check("apply_sin1",    64'(w_sin_1_o),    64'(exp_sin1));
        check("apply_cos2",    64'(w_cos_2_o),    64'(exp_cos2));
        check("apply_sin2",    64'(w_sin_2_o),    64'(exp_sin2));
        check("apply_pulse",   64'(applied_o),    64'd1);
        check("apply_idle",    64'(pending_o),    64'd0);
        tick();
        check("apply_once",    64'(applied_o),    64'd0);

        // 3. Write stalled while pending, lands after apply, visible after next commit+sync
        pulse_commit();
        wr_valid_i = 1'b1;
        wr_addr_i  = AW'(9);
        wr_data_i  = 5'h1F;
        #1;
        check("stall_ready", 64'(wr_ready_o), 64'd0);
        tick();
        tick();
        check("stall_ready_hold", 64'(wr_ready_o), 64'd0);
        pulse_sync();
        check("stall_sin1_old", 64'(w_sin_1_o[1]), 64'd9);
        check("stall_ready_back", 64'(wr_ready_o), 64'd1);
        tick();
        wr_valid_i = 1'b0;
        check("stall_not_active", 64'(w_sin_1_o[1]), 64'd9);
        pulse_commit();
        pulse_sync();
        exp_sin1[1] = 5'h1F;
        check("stall_sin1_new", 64'(w_sin_1_o), 64'(exp_sin1));
        check("persist_cos2",   64'(w_cos_2_o), 64'(exp_cos2));

        // 4. Commit and frame sync together in IDLE: pending only
        tick();
        commit_i     = 1'b1;
        frame_sync_i = 1'b1;
        tick();
        commit_i     = 1'b0;
        frame_sync_i = 1'b0;
        check("same_pending", 64'(pending_o), 64'd1);
        check("same_applied", 64'(applied_o), 64'd0);
        tick();
        check("same_applied_late", 64'(applied_o), 64'd0);
        pulse_sync();
        check("same_next_apply", 64'(applied_o), 64'd1);
        check("same_next_idle",  64'(pending_o), 64'd0);

        // 5. Reset mid-PENDING discards the commit
        tick();
        pulse_commit();
        check("midrst_pending_pre", 64'(pending_o), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_pending", 64'(pending_o),  64'd0);
        check("midrst_ready",   64'(wr_ready_o), 64'd1);
        check("midrst_cos1",    64'(w_cos_1_o),  64'(zero_bank));
        check("midrst_sin2",    64'(w_sin_2_o),  64'(zero_bank));
        pulse_sync();
        check("midrst_no_apply", 64'(applied_o), 64'd0);
        check("midrst_sin1",     64'(w_sin_1_o), 64'(zero_bank));

`ifdef BF_WLOAD_CHECKSUM_EN
        // 6. Checksum accept and reject
        write(AW'(0), 5'd3);
        write(AW'(1), 5'd5);
        commit_sum_i = 5'd6;
        pulse_commit();
        check("sum_ok_pending", 64'(pending_o), 64'd1);
        check("sum_ok_err",     64'(err_o),     64'd0);
        pulse_sync();
        check("sum_ok_cos1_0",  64'(w_cos_1_o[0]), 64'd3);
        check("sum_ok_cos1_1",  64'(w_cos_1_o[1]), 64'd5);
        tick();
        write(AW'(0), 5'd3);
        write(AW'(1), 5'd5);
        commit_sum_i = 5'd7;
        pulse_commit();
        check("sum_bad_err",     64'(err_o),     64'd1);
        check("sum_bad_pending", 64'(pending_o), 64'd0);
        tick();
        check("sum_bad_err_once", 64'(err_o), 64'd0);
        commit_sum_i = 5'd6;
        pulse_commit();
        check("sum_kept_pending", 64'(pending_o), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
